reg_file: RTL

Architectural integer register file with write-back scoreboard; the receiving end of the write-back stage's `regAddrOut`/`regWeOut`/`regWDataOut` write port. It holds x1..x31 and serves two decode-stage read ports with same-cycle write bypass. It tracks per-register pending writes issued by decode, so decode can stall on read-after-write hazards that bypass cannot cover.

---
 rtl/reg_file_pkg.sv | 27 ++
 rtl/reg_file_if.sv | 53 +++++
 rtl/reg_file_pend_counter.sv | 46 ++++
 rtl/reg_file.sv | 127 ++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared constants, types and helpers for the architectural
//               integer register file and its write-back scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    // Codebase-wide data bus width.
    localparam int c_BUS_W    = 32;
    // Register-address width (x0..x31).
    localparam int c_REG_AW   = 5;
    // Number of architectural register indices, x0 included.
    localparam int c_NUM_REGS = 32;

    typedef logic [c_REG_AW-1:0] reg_addr_t;

    // x0 is hardwired to zero: never stored, never tracked.
    localparam reg_addr_t c_X0_ADDR = '0;

    function automatic logic is_x0(input reg_addr_t addr);
        return (addr == c_X0_ADDR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_if
// Description : Decode/write-back facing bus of the register file.
//               master : write-back + decode side (drives *In, samples *Out)
//               slave  : register file
//   wAddrIn/wWeIn/wDataIn     write-back port
//   rAddr1In/rAddr2In         read addresses
//   rData1Out/rData2Out       read data (combinational, with bypass)
//   busy1Out/busy2Out         read register has an uncovered pending write
//   issueValidIn/issueAddrIn  decode issues an instruction writing issueAddrIn
//   issueReadyOut             destination counter can take one more write
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int BUS_W = c_BUS_W
) ();

    reg_addr_t        wAddrIn;
    logic             wWeIn;
    logic [BUS_W-1:0] wDataIn;

    reg_addr_t        rAddr1In;
    reg_addr_t        rAddr2In;
    logic [BUS_W-1:0] rData1Out;
    logic [BUS_W-1:0] rData2Out;
    logic             busy1Out;
    logic             busy2Out;

    logic             issueValidIn;
    reg_addr_t        issueAddrIn;
    logic             issueReadyOut;

    modport master (
        output wAddrIn, wWeIn, wDataIn,
        output rAddr1In, rAddr2In,
        input  rData1Out, rData2Out, busy1Out, busy2Out,
        output issueValidIn, issueAddrIn,
        input  issueReadyOut
    );

    modport slave (
        input  wAddrIn, wWeIn, wDataIn,
        input  rAddr1In, rAddr2In,
        output rData1Out, rData2Out, busy1Out, busy2Out,
        input  issueValidIn, issueAddrIn,
        output issueReadyOut
    );

endinterface
`default_nettype wire

// File: rtl/reg_file_pend_counter.sv
`default_nettype none
// ============================================================================
// Module      : pend_counter
// Description : Saturating up/down counter of in-flight writes to one
//               architectural register.
//   clk, rst      clock, asynchronous active-low reset
//   i_inc, i_dec  one issue recorded / one write-back landed
//   o_count       current pending-write count
//   o_full        count at 2^PEND_W-1
//   o_nonzero     count above zero
// Revision    : 1.0 - initial release
// ============================================================================
module pend_counter #(
    parameter int PEND_W = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_inc,
    input  wire logic              i_dec,
    output logic      [PEND_W-1:0] o_count,
    output logic                   o_full,
    output logic                   o_nonzero
);

    localparam logic [PEND_W-1:0] c_ONE = PEND_W'(1);

    logic [PEND_W-1:0] r_count;

    // Simultaneous inc and dec cancel. A write-back with nothing pending
    // (e.g. in flight across a reset) is legal and leaves the count at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && !o_full) begin
            r_count <= r_count + c_ONE;
        end else if (i_dec && !i_inc && o_nonzero) begin
            r_count <= r_count - c_ONE;
        end
    end

    assign o_count   = r_count;
    assign o_full    = &r_count;
    assign o_nonzero = |r_count;

endmodule
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : Architectural integer register file (x1..x31) with two
//               combinational read ports, same-cycle write bypass, and a
//               per-register pending-write scoreboard for decode stalls.
//   clk   clock
//   rst   asynchronous active-low reset
//   bus   reg_file_if.slave: write-back, read and issue ports
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import reg_file_pkg::*;
#(
    parameter int BUS_W  = c_BUS_W,
    parameter int PEND_W = 2
) (
    input wire logic clk,
    input wire logic rst,
    reg_file_if.slave bus
);

    localparam logic [PEND_W-1:0] c_ONE = PEND_W'(1);

    // Storage has no x0 entry.
    logic [BUS_W-1:0]  r_regs [1:c_NUM_REGS-1];

    // Index 0 of the scoreboard views is tied off so x0 never stalls.
    logic [c_NUM_REGS-1:0] w_dec;
    logic [c_NUM_REGS-1:0] w_full;
    logic [c_NUM_REGS-1:0] w_nonzero;
    logic [c_NUM_REGS-1:1] w_inc;
    logic [PEND_W-1:0]     w_cnt [0:c_NUM_REGS-1];

    logic [BUS_W-1:0]      w_rdata1;
    logic [BUS_W-1:0]      w_rdata2;
    logic                  w_busy1;
    logic                  w_busy2;
    logic                  w_issue_ready;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.wWeIn && !is_x0(bus.wAddrIn)) begin
            r_regs[bus.wAddrIn] <= bus.wDataIn;
        end
    end

    // ------------------------------------------------------------------
    // Pending-write scoreboard
    // ------------------------------------------------------------------
    assign w_dec[0]     = 1'b0;
    assign w_full[0]    = 1'b0;
    assign w_nonzero[0] = 1'b0;
    assign w_cnt[0]     = '0;

    generate
        for (genvar r = 1; r < c_NUM_REGS; r++) begin : g_pend
            assign w_dec[r] = bus.wWeIn && (bus.wAddrIn == reg_addr_t'(r));
            // Only accepted issues count; a refused issue is held by decode.
            assign w_inc[r] = bus.issueValidIn && w_issue_ready &&
                              (bus.issueAddrIn == reg_addr_t'(r));

            pend_counter #(
                .PEND_W    (PEND_W)
            ) u_pend (
                .clk       (clk),
                .rst       (rst),
                .i_inc     (w_inc[r]),
                .i_dec     (w_dec[r]),
                .o_count   (w_cnt[r]),
                .o_full    (w_full[r]),
                .o_nonzero (w_nonzero[r])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read ports: x0 -> 0, then same-cycle write bypass, then storage
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata1 = '0;
        if (!is_x0(bus.rAddr1In)) begin
            if (bus.wWeIn && (bus.wAddrIn == bus.rAddr1In)) begin
                w_rdata1 = bus.wDataIn;
            end else begin
                w_rdata1 = r_regs[bus.rAddr1In];
            end
        end
    end

    always_comb begin
        w_rdata2 = '0;
        if (!is_x0(bus.rAddr2In)) begin
            if (bus.wWeIn && (bus.wAddrIn == bus.rAddr2In)) begin
                w_rdata2 = bus.wDataIn;
            end else begin
                w_rdata2 = r_regs[bus.rAddr2In];
            end
        end
    end

    // A lone pending write landing this cycle is covered by the bypass;
    // with two or more outstanding the bypassed value is not the final one.
    assign w_busy1 = w_nonzero[bus.rAddr1In] &&
                     !((w_cnt[bus.rAddr1In] == c_ONE) && w_dec[bus.rAddr1In]);
    assign w_busy2 = w_nonzero[bus.rAddr2In] &&
                     !((w_cnt[bus.rAddr2In] == c_ONE) && w_dec[bus.rAddr2In]);

    // A full counter frees a slot when its write-back lands this cycle.
    assign w_issue_ready = is_x0(bus.issueAddrIn) ||
                           !w_full[bus.issueAddrIn] ||
                           w_dec[bus.issueAddrIn];

    assign bus.rData1Out     = w_rdata1;
    assign bus.rData2Out     = w_rdata2;
    assign bus.busy1Out      = w_busy1;
    assign bus.busy2Out      = w_busy2;
    assign bus.issueReadyOut = w_issue_ready;

endmodule
`default_nettype wire
